// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: run-ahead instruction fetch front end.
// One outstanding imem request, small queue feeding IF/ID.
module instr_prefetch_unit #(
  parameter int              AW       = 10,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          out_valid,
  output logic [31:0]   out_ir,
  output logic [AW-1:0] out_npc,
  output logic          halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, WAIT, DROP, HALT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   q_ir  [DEPTH];
  logic [AW-1:0] q_npc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] lim;
  logic [AW-1:0] pc, pc_nxt;
  logic          push, pop, issue, is_hlt;

  assign out_valid = (count != '0);
  assign pop       = out_valid && !stall;
  assign is_hlt    = (imem_rdata[31:26] == 6'b111111);
  assign halted    = (state == HALT);
  assign out_ir    = out_valid ? q_ir[rd_ptr]  : 32'h0;
  assign out_npc   = out_valid ? q_npc[rd_ptr] : '0;

  // the slot freed by a same-cycle pop may be reused by the next fetch
  assign lim = pop ? FULL : FULL - CW'(1);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: redirect wins; a response that meets a redirect is spent
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if ((state == WAIT || state == DROP) && !imem_rvalid)
        state_nxt = DROP;
      else
        state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (issue) state_nxt = WAIT;
        WAIT: if (imem_rvalid)
                state_nxt = is_hlt ? HALT : (issue ? WAIT : IDLE);
        DROP: if (imem_rvalid)
                state_nxt = issue ? WAIT : IDLE;
        HALT: state_nxt = HALT;
      endcase
    end
  end

  // outputs: push, fetch decision and next pc
  always_comb begin
    push   = 1'b0;
    issue  = 1'b0;
    pc_nxt = pc;
    if (!redirect_valid) begin
      unique case (state)
        IDLE: issue = (count < FULL);
        WAIT: if (imem_rvalid) begin
                push   = 1'b1;
                pc_nxt = pc + AW'(1);
                issue  = !is_hlt && (count < lim);
              end
        DROP: if (imem_rvalid) issue = (count < FULL);
        HALT: issue = 1'b0;
      endcase
    end
  end

  // pc, request register and queue bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      imem_req <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pc       <= pc_nxt;
      imem_req <= issue;
      if (issue) imem_addr <= pc_nxt;
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // queue storage, written with the word and its successor address
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_ir[wr_ptr]  <= imem_rdata;
      q_npc[wr_ptr] <= imem_addr + AW'(1);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit: random-latency memory, stream model,
// directed scenarios for stall, redirect, halt, reset, wrap.
module tb_instr_prefetch_unit;

  localparam int AW = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [AW-1:0] out_npc;
  logic          halted;

  logic        rst4, req4, rvalid4, redir4, stall4, ov4, halted4;
  logic [3:0]  addr4, rpc4, npc4;
  logic [31:0] rdata4, ir4;

  instr_prefetch_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .out_valid(out_valid), .out_ir(out_ir),
    .out_npc(out_npc), .halted(halted)
  );

  instr_prefetch_unit #(.AW(4), .DEPTH(2), .RESET_PC(4'd0)) dut4 (
    .clk(clk), .rst(rst4),
    .imem_req(req4), .imem_addr(addr4),
    .imem_rvalid(rvalid4), .imem_rdata(rdata4),
    .redirect_valid(redir4), .redirect_pc(rpc4),
    .stall(stall4), .out_valid(ov4), .out_ir(ir4),
    .out_npc(npc4), .halted(halted4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mem [1024];
  int lat_min = 1;
  int lat_max = 1;

  // memory responder: latency counted from the request cycle
  bit pend;
  int cnt;
  logic [AW-1:0] paddr;
  initial begin
    pend = 0; cnt = 0; paddr = '0;
    imem_rvalid = 0; imem_rdata = 0;
    forever begin
      @(negedge clk);
      imem_rvalid = 0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1;
          imem_rdata = mem[paddr];
          pend = 0;
        end
      end
      if (imem_req) begin
        n_checks++;
        if (pend) begin
          n_fail++;
          $display("FAIL one_outstanding: req to %0d while %0d pending", imem_addr, paddr);
        end
        pend = 1;
        paddr = imem_addr;
        cnt = int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  // stream model: reqs walk pc upward, outputs are mem[a] with npc a+1
  int exp_req, exp_out;
  bit no_more_req;
  initial begin
    exp_req = 0; exp_out = 0; no_more_req = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        exp_req = 0; exp_out = 0; no_more_req = 0;
      end else begin
        if (imem_req) begin
          n_checks++;
          if (no_more_req || imem_addr !== AW'(exp_req)) begin
            n_fail++;
            $display("FAIL req_addr: got %0d expected %0d after_hlt=%0d", imem_addr, exp_req, no_more_req);
          end
          if (mem[imem_addr][31:26] == 6'h3f) no_more_req = 1;
          exp_req = (exp_req + 1) & 1023;
        end
        if (redirect_valid) begin
          exp_req = int'(redirect_pc);
          exp_out = int'(redirect_pc);
          no_more_req = 0;
        end else if (out_valid && !stall) begin
          n_checks++;
          if (out_ir !== mem[exp_out] || out_npc !== AW'((exp_out + 1) & 1023)) begin
            n_fail++;
            $display("FAIL pop_word: got ir=%h npc=%0d expected ir=%h npc=%0d", out_ir, out_npc, mem[exp_out], (exp_out + 1) & 1023);
          end
          exp_out = (exp_out + 1) & 1023;
        end else if (!out_valid) begin
          n_checks++;
          if (out_ir !== 32'h0 || out_npc !== '0) begin
            n_fail++;
            $display("FAIL empty_out: got ir=%h npc=%0d expected 0", out_ir, out_npc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(int cycles);
    @(negedge clk);
    rst = 1; redirect_valid = 0; stall = 0;
    repeat (cycles) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset(5);
    #1;
    n_checks += 5;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0d expected 0", imem_req); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0d expected 0", out_valid); end
    if (out_ir !== 32'h0) begin n_fail++; $display("FAIL rst_ir: got %h expected 0", out_ir); end
    if (out_npc !== '0) begin n_fail++; $display("FAIL rst_npc: got %0d expected 0", out_npc); end
    if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %0d expected 0", halted); end
  endtask

  task automatic test_fetch_stream();
    int ra[$];
    int rt[$];
    int cyc;
    bit seen;
    lat_min = 1; lat_max = 1;
    do_reset(5);
    cyc = 0; seen = 0;
    while (ra.size() < 8 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (imem_req) begin ra.push_back(int'(imem_addr)); rt.push_back(cyc); end
      if (out_valid && !seen) begin
        seen = 1;
        n_checks++;
        if (out_npc !== AW'(1) || out_ir !== mem[0]) begin
          n_fail++;
          $display("FAIL first_out: got ir=%h npc=%0d expected ir=%h npc=1", out_ir, out_npc, mem[0]);
        end
      end
    end
    n_checks++;
    if (ra.size() != 8) begin n_fail++; $display("FAIL stream_reqs: got %0d reqs expected 8", ra.size()); end
    n_checks++;
    if (rt.size() > 0 && rt[0] != 1) begin n_fail++; $display("FAIL first_req_cycle: got %0d expected 1", rt[0]); end
    for (int i = 0; i < ra.size(); i++) begin
      n_checks++;
      if (ra[i] != i) begin n_fail++; $display("FAIL stream_addr%0d: got %0d expected %0d", i, ra[i], i); end
      if (i > 0) begin
        n_checks++;
        if (rt[i] - rt[i-1] != 2) begin n_fail++; $display("FAIL back_to_back%0d: got gap %0d expected 2", i, rt[i] - rt[i-1]); end
      end
    end
  endtask

  task automatic test_stall();
    int total, late;
    int got[$];
    lat_min = 1; lat_max = 1;
    do_reset(5);
    stall = 1;
    total = 0; late = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (imem_req) begin total++; if (c >= 10) late++; end
    end
    n_checks += 3;
    if (total != DEPTH) begin n_fail++; $display("FAIL stall_fill: got %0d reqs expected %0d", total, DEPTH); end
    if (late != 0) begin n_fail++; $display("FAIL stall_full_req: got %0d reqs expected 0", late); end
    if (out_valid !== 1'b1 || out_ir !== mem[0] || out_npc !== AW'(1)) begin
      n_fail++;
      $display("FAIL stall_head: got v=%0d ir=%h npc=%0d expected v=1 ir=%h npc=1", out_valid, out_ir, out_npc, mem[0]);
    end
    @(negedge clk);
    stall = 0;
    for (int c = 0; c < DEPTH; c++) begin
      #1;
      if (out_valid) got.push_back(out_ir);
      @(negedge clk);
    end
    n_checks++;
    if (got.size() != DEPTH) begin n_fail++; $display("FAIL drain_count: got %0d expected %0d", got.size(), DEPTH); end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== mem[i]) begin n_fail++; $display("FAIL drain_order%0d: got %h expected %h", i, got[i], mem[i]); end
    end
  endtask

  task automatic test_redirect();
    int n;
    lat_min = 3; lat_max = 3;
    do_reset(5);
    n = 0;
    while (!(imem_req && imem_addr == AW'(5)) && n < 80) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 80) begin n_fail++; $display("FAIL wait_req5: timed out, got none expected req to 5"); end
    @(negedge clk);
    redirect_valid = 1; redirect_pc = AW'(40);
    @(negedge clk);
    redirect_valid = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush: got out_valid=%0d expected 0", out_valid); end
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== AW'(40)) begin
      n_fail++;
      $display("FAIL redirect_req: got req=%0d addr=%0d expected req to 40", imem_req, imem_addr);
    end
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (out_valid !== 1'b1 || out_npc !== AW'(41) || out_ir !== mem[40]) begin
      n_fail++;
      $display("FAIL redirect_out: got v=%0d npc=%0d ir=%h expected npc=41 ir=%h", out_valid, out_npc, out_ir, mem[40]);
    end
  endtask

  task automatic test_halt();
    int n, reqs;
    logic [31:0] saved;
    saved = mem[6];
    mem[6] = 32'hFC000000;
    lat_min = 1; lat_max = 1;
    do_reset(5);
    n = 0;
    while (!(imem_req && imem_addr == AW'(6)) && n < 60) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 60) begin n_fail++; $display("FAIL wait_req6: timed out, got none expected req to 6"); end
    @(negedge clk); #1;
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %0d expected 0", halted); end
    @(negedge clk); #1;
    n_checks++;
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %0d expected 1", halted); end
    reqs = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); #1; if (imem_req) reqs++; end
    n_checks += 2;
    if (reqs != 0) begin n_fail++; $display("FAIL halt_noreq: got %0d reqs expected 0", reqs); end
    if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %0d expected 1", halted); end
    @(negedge clk);
    redirect_valid = 1; redirect_pc = AW'(20);
    @(negedge clk);
    redirect_valid = 0;
    #1;
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %0d expected 0", halted); end
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== AW'(20)) begin
      n_fail++;
      $display("FAIL halt_resume: got req=%0d addr=%0d expected req to 20", imem_req, imem_addr);
    end
    mem[6] = saved;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    lat_min = 3; lat_max = 3;
    do_reset(5);
    n = 0;
    while (!(imem_req && imem_addr == AW'(3)) && n < 60) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (n >= 60) begin n_fail++; $display("FAIL wait_req3: timed out, got none expected req to 3"); end
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%0d rvalid=%0d expected v=0 rvalid=1", out_valid, imem_rvalid);
    end
    @(negedge clk); #1;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ignore: got out_valid=%0d expected 0", out_valid); end
    if (imem_req !== 1'b1 || imem_addr !== AW'(0)) begin
      n_fail++;
      $display("FAIL rst_first_req: got req=%0d addr=%0d expected req to 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    int pops;
    lat_min = 1; lat_max = 4;
    do_reset(5);
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stall = ($urandom_range(99, 0) < 30);
      redirect_valid = ($urandom_range(99, 0) < 3);
      redirect_pc = AW'($urandom_range(1023, 0));
      #1;
      if (out_valid && !stall && !redirect_valid) pops++;
      if (imem_req) begin
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL req_while_halted: got req to %0d with halted=1", imem_addr); end
      end
    end
    @(negedge clk);
    redirect_valid = 0; stall = 0;
    n_checks++;
    if (pops < 200) begin n_fail++; $display("FAIL random_progress: got %0d pops expected at least 200", pops); end
  endtask

  task automatic test_wrap_aw4();
    int n, reqs;
    stall4 = 1; redir4 = 0; rvalid4 = 0; rdata4 = 0; rpc4 = 0; rst4 = 1;
    repeat (3) @(negedge clk);
    rst4 = 0; redir4 = 1; rpc4 = 4'd15;
    @(negedge clk);
    redir4 = 0;
    n = 0;
    while (!req4 && n < 10) begin @(negedge clk); #1; n++; end
    n_checks++;
    if (req4 !== 1'b1 || addr4 !== 4'd15) begin n_fail++; $display("FAIL wrap_req15: got req=%0d addr=%0d expected req to 15", req4, addr4); end
    @(negedge clk);
    rvalid4 = 1; rdata4 = 32'h1234_5678;
    @(negedge clk);
    rvalid4 = 0;
    #1;
    n_checks += 2;
    if (ov4 !== 1'b1 || ir4 !== 32'h1234_5678 || npc4 !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_npc: got v=%0d ir=%h npc=%0d expected v=1 ir=12345678 npc=0", ov4, ir4, npc4);
    end
    if (req4 !== 1'b1 || addr4 !== 4'd0) begin n_fail++; $display("FAIL wrap_req0: got req=%0d addr=%0d expected req to 0", req4, addr4); end
    @(negedge clk);
    rvalid4 = 1; rdata4 = 32'hCAFE_0001;
    @(negedge clk);
    rvalid4 = 0;
    reqs = 0;
    for (int c = 0; c < 10; c++) begin #1; if (req4) reqs++; @(negedge clk); end
    n_checks += 2;
    if (reqs != 0) begin n_fail++; $display("FAIL d2_full_req: got %0d reqs expected 0", reqs); end
    if (ir4 !== 32'h1234_5678) begin n_fail++; $display("FAIL d2_head: got %h expected 12345678", ir4); end
    stall4 = 0;
    @(negedge clk); #1;
    n_checks++;
    if (ov4 !== 1'b1 || ir4 !== 32'hCAFE_0001 || npc4 !== 4'd1) begin
      n_fail++;
      $display("FAIL d2_second: got v=%0d ir=%h npc=%0d expected ir=cafe0001 npc=1", ov4, ir4, npc4);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'h3f) w[26] = 1'b0;
      mem[i] = w;
    end
    mem[500] = 32'hFC00_0001;
    mem[700] = 32'hFC00_0002;
    mem[900] = 32'hFC00_0003;
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = '0;
    rst4 = 1; stall4 = 1; redir4 = 0; rpc4 = 0; rvalid4 = 0; rdata4 = 0;
    test_reset();
    test_fetch_stream();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid_wait();
    test_random();
    test_wrap_aw4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
